seven_segments_reader: RTL and testbench
========================================

SEVEN_SEGMENTS_READER -- requirements
Module: seven_segments_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required to accept a digit.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port display, input, 7, segment bus; bit0=seg1 (top), bit1=seg2, bit2=seg3, bit3=seg4, bit4=seg5, bit5=seg6, bit6=seg7 (middle), 1=lit.
REQ-005 SHALL have port digit_sel, input, 4, one-hot digit enable of a multiplexed 4-digit display; bit0=least significant digit.
REQ-006 SHALL have port value, output, 16, last complete frame as BCD; value[3:0]=digit 0 ... value[15:12]=digit 3.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when value updates.
REQ-008 SHALL have port err, output, 1, one-cycle pulse when an invalid pattern is accepted.
REQ-009 SHALL have port err_count, output, 8, saturating error count (present only per REQ-027).

Function
REQ-010 SHALL decode only 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9; every other pattern, including 0x79 ("E"), is invalid.
REQ-011 SHALL treat digit_sel not one-hot (zero or multi-hot) as no-select: state IDLE, stability count 0, no accept, no err.
REQ-012 SHALL run per-sample FSM states IDLE, TRACK, HELD.
REQ-013 IDLE->TRACK when digit_sel is one-hot; count set to 1.
REQ-014 TRACK: {digit_sel,display} equal to previous cycle -> count+1; different one-hot pair -> stay TRACK, count=1; no-select -> IDLE.
REQ-015 SHALL accept the sample on the edge where count reaches STABLE_CYCLES (STABLE_CYCLES=1: first cycle), then enter HELD.
REQ-016 HELD: no further accept while the pair is unchanged; change to a new one-hot pair -> TRACK count=1; no-select -> IDLE.
REQ-017 Valid accept SHALL write the decoded BCD into the shadow nibble of the selected digit and set its seen bit; re-accept of an already-seen digit overwrites its nibble.
REQ-018 When the accept sets the fourth seen bit, on that same edge value SHALL load the full shadow (including the new nibble), valid SHALL be high for exactly the following cycle, and all seen bits SHALL clear.
REQ-019 Invalid accept SHALL pulse err for exactly the following cycle, leave shadow and seen bits unchanged, and leave value unchanged.
REQ-020 Accept latency SHALL be STABLE_CYCLES cycles from the first cycle of a new stable pair to the edge of acceptance; valid/err observed one cycle later.
REQ-021 value SHALL hold between frames; valid and err SHALL never be high simultaneously.

Reset
REQ-022 rst_n low SHALL immediately force value=0, valid=0, err=0, err_count=0, seen=0, shadow=0, count=0, state IDLE, previous-sample register=0.
REQ-023 Reset mid-frame SHALL discard partial shadow; first valid after release requires four fresh accepts.
REQ-024 SHALL resume sampling on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro SEVEN_SEGMENTS_READER_ERR_COUNT_EN.
REQ-026 Defined: err_count increments by 1 on each invalid accept, saturates at 255, clears only on reset.
REQ-027 Undefined: err_count port SHALL be absent and no counter logic generated; all other behaviour identical.

Verification
REQ-028 STABLE_CYCLES=4; hold each of digits 0..3 for 5 cycles with patterns 0x06,0x5B,0x4F,0x66 -> value=0x4321, valid one cycle after 4th accept.
REQ-029 Hold digit 0 pattern 0x3F for 3 cycles then change -> no accept, seen unchanged, valid never asserted.
REQ-030 Hold digit 1 pattern 0x79 for 4 cycles -> err pulse one cycle; value unchanged; err_count=1 when macro defined.
REQ-031 Digit_sel=4'b0011 with any pattern for 10 cycles -> no accept, no err, state IDLE.
REQ-032 Accept digits 0..2, pulse rst_n low mid-TRACK of digit 3 -> all outputs 0 immediately; then full 4-digit frame 0x9876 -> value=0x9876.
REQ-033 256+ invalid accepts with macro defined -> err_count holds 255.

Source files
------------

// File: rtl/seven_segments_reader.sv
// Samples a multiplexed 4-digit seven-segment bus and rebuilds the shown number as BCD.
// Optional saturating error counter enabled by SEVEN_SEGMENTS_READER_ERR_COUNT_EN.
module seven_segments_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  display,
  input  logic [3:0]  digit_sel,
  output logic [15:0] value,
  output logic        valid,
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
  output logic        err,
  output logic [7:0]  err_count
`else
  output logic        err
`endif
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [10:0]   prev;
  logic [3:0]    seen;
  logic [15:0]   shadow;

  logic          onehot_c;
  logic          same_c;
  logic          code_ok_c;
  logic [3:0]    bcd_c;
  logic [1:0]    idx_c;
  logic [CW-1:0] next_count_c;
  logic          accept_c;
  logic [3:0]    seen_set_c;
  logic [15:0]   shadow_next_c;

  // Sample classification, stability count and accept decision
  always_comb begin
    code_ok_c = 1'b1;
    bcd_c     = 4'd0;
    case (display)
      7'h3F:   bcd_c = 4'd0;
      7'h06:   bcd_c = 4'd1;
      7'h5B:   bcd_c = 4'd2;
      7'h4F:   bcd_c = 4'd3;
      7'h66:   bcd_c = 4'd4;
      7'h6D:   bcd_c = 4'd5;
      7'h7D:   bcd_c = 4'd6;
      7'h07:   bcd_c = 4'd7;
      7'h7F:   bcd_c = 4'd8;
      7'h6F:   bcd_c = 4'd9;
      default: code_ok_c = 1'b0;
    endcase

    idx_c = 2'd0;
    case (digit_sel)
      4'b0010: idx_c = 2'd1;
      4'b0100: idx_c = 2'd2;
      4'b1000: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase

    onehot_c = (digit_sel != 4'd0) && ((digit_sel & (digit_sel - 4'd1)) == 4'd0);
    same_c   = ({digit_sel, display} == prev);

    next_count_c = CW'(1);
    if (state == TRACK && same_c)
      next_count_c = count + CW'(1);

    accept_c = onehot_c && !(state == HELD && same_c) && (next_count_c == STABLE);

    seen_set_c    = seen | 4'(4'b0001 << idx_c);
    shadow_next_c = (shadow & ~(16'h000F << {idx_c, 2'b00})) | (16'(bcd_c) << {idx_c, 2'b00});
  end

  // Sampler FSM, frame assembly and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      prev   <= '0;
      seen   <= '0;
      shadow <= '0;
      value  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
      err_count <= '0;
`endif
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      prev  <= {digit_sel, display};

      if (!onehot_c) begin
        state <= IDLE;
        count <= '0;
      end else if (!(state == HELD && same_c)) begin
        count <= next_count_c;
        state <= accept_c ? HELD : TRACK;
      end

      if (accept_c) begin
        if (code_ok_c) begin
          shadow <= shadow_next_c;
          if (seen_set_c == 4'hF) begin
            value <= shadow_next_c;
            valid <= 1'b1;
            seen  <= 4'h0;
          end else begin
            seen <= seen_set_c;
          end
        end else begin
          err <= 1'b1;
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
          if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segments_reader.sv
// Randomized bench for seven_segments_reader against a run-length based reference model.
module tb_seven_segments_reader;

  localparam int STAB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  display = '0;
  logic [3:0]  digit_sel = '0;
  logic [15:0] value;
  logic        valid;
  logic        err;
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  seven_segments_reader #(.STABLE_CYCLES(STAB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .display(display),
    .digit_sel(digit_sel),
    .value(value),
    .valid(valid),
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
    .err(err),
    .err_count(err_count)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: length of the current run of identical one-hot samples
  logic [10:0] m_prev = '0;
  int          m_run = 0;
  int          m_shadow [4] = '{0, 0, 0, 0};
  bit          m_seen [4] = '{0, 0, 0, 0};
  logic [15:0] m_value = '0;
  int          m_errcnt = 0;
  bit          m_valid = 0;
  bit          m_err = 0;
  int          valid_seen = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_value = '0; m_errcnt = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_seen[i] = 0; end
  endtask

  task automatic model_update(input logic [3:0] sel, input logic [6:0] disp);
    logic [10:0] s;
    bit oh;
    int idx, d;
    s = {sel, disp};
    oh = ($countones(sel) == 1);
    if (!oh) m_run = 0;
    else if (m_run > 0 && s == m_prev) m_run++;
    else m_run = 1;
    m_prev = s;
    m_valid = 0;
    m_err = 0;
    if (oh && m_run == STAB) begin
      idx = 0; d = -1;
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
      for (int k = 0; k < 10; k++) if (pats[k] == disp) d = k;
      if (d >= 0) begin
        m_shadow[idx] = d;
        m_seen[idx] = 1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
          m_value = 16'(m_shadow[3] * 4096 + m_shadow[2] * 256 + m_shadow[1] * 16 + m_shadow[0]);
          m_valid = 1;
          for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end
      end else begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".value"}, value, m_value);
    check({tag, ".valid"}, 16'(valid), 16'(m_valid));
    check({tag, ".err"}, 16'(err), 16'(m_err));
`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
    check({tag, ".err_count"}, 16'(err_count), 16'(m_errcnt));
`endif
  endtask

  task automatic step(input string tag, input logic [3:0] sel, input logic [6:0] disp);
    @(negedge clk);
    digit_sel = sel;
    display = disp;
    @(posedge clk);
    #1;
    model_update(sel, disp);
    if (valid) valid_seen++;
    check_outputs(tag);
  endtask

  task automatic hold(input string tag, input logic [3:0] sel, input logic [6:0] disp, input int n);
    for (int i = 0; i < n; i++) step(tag, sel, disp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset_async");
    digit_sel = '0;
    display = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sel;
    logic [6:0] disp;
    int len;

    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 4321 with each digit held one cycle past the stability window
    hold("frame4321", 4'b0001, 7'h06, 5);
    hold("frame4321", 4'b0010, 7'h5B, 5);
    hold("frame4321", 4'b0100, 7'h4F, 5);
    step("frame4321", 4'b1000, 7'h66);
    step("frame4321", 4'b1000, 7'h66);
    step("frame4321", 4'b1000, 7'h66);
    step("frame4321", 4'b1000, 7'h66);
    check("frame4321.direct", value, 16'h4321);
    check("frame4321.pulse", 16'(valid), 16'd1);
    step("frame4321", 4'b1000, 7'h66);
    check("frame4321.one_cycle", 16'(valid), 16'd0);

    // Too-short hold, then change: no accept
    valid_seen = 0;
    hold("short", 4'b0001, 7'h3F, 3);
    hold("short", 4'b0010, 7'h06, 2);
    hold("short", 4'b0000, 7'h00, 2);
    check("short.no_valid", 16'(valid_seen), 16'd0);

    // Invalid "E" on digit 1
    hold("err_e", 4'b0010, 7'h79, 4);
    check("err_e.pulse", 16'(err), 16'd1);
    check("err_e.value", value, 16'h4321);
    step("err_e", 4'b0010, 7'h79);
    check("err_e.one_cycle", 16'(err), 16'd0);

    // Multi-hot select never accepts
    hold("multihot", 4'b0011, 7'h06, 10);
    hold("multihot", 4'b0000, 7'h00, 1);

    // Reset in the middle of digit 3 tracking, then fresh frame 9876
    hold("pre_reset", 4'b0001, 7'h3F, 4);
    hold("pre_reset", 4'b0010, 7'h06, 4);
    hold("pre_reset", 4'b0100, 7'h5B, 4);
    hold("pre_reset", 4'b1000, 7'h4F, 2);
    pulse_reset();
    hold("frame9876", 4'b0001, 7'h7D, 4);
    hold("frame9876", 4'b0010, 7'h07, 4);
    hold("frame9876", 4'b0100, 7'h7F, 4);
    hold("frame9876", 4'b1000, 7'h6F, 4);
    check("frame9876.direct", value, 16'h9876);
    check("frame9876.pulse", 16'(valid), 16'd1);

`ifdef SEVEN_SEGMENTS_READER_ERR_COUNT_EN
    // Saturation: alternate digits so every hold is a fresh invalid accept
    for (int i = 0; i < 260; i++)
      hold("sat", (i % 2 == 0) ? 4'b0001 : 4'b0010, 7'h79, STAB);
    check("sat.direct", 16'(err_count), 16'd255);
`endif

    // Random holds of random length over mostly legal traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 85) sel = 4'(4'b0001 << $urandom_range(0, 3));
      else sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 75) disp = pats[$urandom_range(0, 9)];
      else disp = 7'($urandom_range(0, 127));
      len = int'($urandom_range(1, 6));
      hold("random", sel, disp, len);
      if ($urandom_range(0, 99) < 2) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
